// File: rtl/ysyx_24100012_lsu.sv
// Load/store unit: one aligned 32-bit bus access per request, with sign/zero-extended load return.
// Latency: 3 cycles from input handshake to wb_valid on a zero-wait bus; 1 cycle for a rejected misaligned access.
// Backpressure: in_ready only in IDLE; REQ holds while mem_req_ready is low, RESP holds while wb_ready is low.
// Optional feature: define YSYX_24100012_LSU_MISALIGN_EN to reject misaligned H/W accesses with wb_err.
module ysyx_24100012_lsu #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_we,
    input  logic [2:0]                in_funct3,
    input  logic [DATA_WIDTH-1:0]     in_addr,
    input  logic [DATA_WIDTH-1:0]     in_wdata,
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic                      mem_we,
    output logic [DATA_WIDTH-1:0]     mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    output logic [DATA_WIDTH/8-1:0]   mem_wstrb,
    input  logic                      mem_rvalid,
    input  logic [DATA_WIDTH-1:0]     mem_rdata,
    output logic                      wb_valid,
    input  logic                      wb_ready,
    output logic [DATA_WIDTH-1:0]     wb_data,
    output logic                      wb_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic                    we_q, we_d;
    logic [2:0]              funct3_q, funct3_d;
    logic [DATA_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   wb_data_q, wb_data_d;
    logic                    wb_err_q, wb_err_d;

    logic                    misalign;
    logic [DATA_WIDTH-1:0]   load_ext;
    logic [DATA_WIDTH-1:0]   store_wdata;
    logic [3:0]              store_wstrb;
    logic [7:0]              ld_byte;
    logic [15:0]             ld_half;

    // Alignment check on the incoming request; funct3[1:0]==01 is a halfword, funct3[1]==1 is word width
`ifdef YSYX_24100012_LSU_MISALIGN_EN
    always_comb begin
        misalign = ((in_funct3[1:0] == 2'b01) && in_addr[0])
                || (in_funct3[1] && (in_addr[1:0] != 2'b00));
    end
`else
    always_comb begin
        misalign = 1'b0;
    end
`endif

    // State and captured-request registers; reset drops any in-flight access
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            we_q      <= 1'b0;
            funct3_q  <= 3'b000;
            addr_q    <= '0;
            wdata_q   <= '0;
            wb_data_q <= '0;
            wb_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            funct3_q  <= funct3_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wb_data_q <= wb_data_d;
            wb_err_q  <= wb_err_d;
        end
    end

    // Next-state logic; mem_rvalid only matters in WAIT, so a response in any other state is dropped
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_valid)      state_d = misalign ? RESP : REQ;
            REQ:  if (mem_req_ready) state_d = WAIT;
            WAIT: if (mem_rvalid)    state_d = RESP;
            RESP: if (wb_ready)      state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    // Load extraction: byte lane by addr[1:0], halfword by addr[1]; funct3[2] selects zero-extension
    always_comb begin
        ld_byte  = 8'h00;
        ld_half  = 16'h0000;
        load_ext = '0;
        case (addr_q[1:0])
            2'b00:   ld_byte = mem_rdata[7:0];
            2'b01:   ld_byte = mem_rdata[15:8];
            2'b10:   ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q[1:0])
            2'b00:   load_ext = {{24{ld_byte[7] & ~funct3_q[2]}}, ld_byte};
            2'b01:   load_ext = {{16{ld_half[15] & ~funct3_q[2]}}, ld_half};
            default: load_ext = mem_rdata;
        endcase
    end

    // Captured-request and writeback data updates
    always_comb begin
        we_d      = we_q;
        funct3_d  = funct3_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wb_data_d = wb_data_q;
        wb_err_d  = wb_err_q;
        if ((state_q == IDLE) && in_valid) begin
            we_d      = in_we;
            funct3_d  = in_funct3;
            addr_d    = in_addr;
            wdata_d   = in_wdata;
            wb_data_d = '0;
            wb_err_d  = misalign;
        end else if ((state_q == WAIT) && mem_rvalid) begin
            wb_data_d = we_q ? '0 : load_ext;
        end
    end

    // Store lane replication and byte strobes; loads never assert strobes
    always_comb begin
        store_wdata = wdata_q;
        store_wstrb = 4'b0000;
        case (funct3_q[1:0])
            2'b00: begin
                store_wdata = {4{wdata_q[7:0]}};
                store_wstrb = 4'b0001 << addr_q[1:0];
            end
            2'b01: begin
                store_wdata = {2{wdata_q[15:0]}};
                store_wstrb = 4'b0011 << {addr_q[1], 1'b0};
            end
            default: begin
                store_wdata = wdata_q;
                store_wstrb = 4'b1111;
            end
        endcase
        if (!we_q) begin
            store_wstrb = 4'b0000;
        end
    end

    // Outputs: bus fields are only driven in REQ so they read zero while idle or waiting
    always_comb begin
        in_ready      = (state_q == IDLE);
        mem_req_valid = (state_q == REQ);
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        mem_wstrb     = '0;
        if (state_q == REQ) begin
            mem_we    = we_q;
            mem_addr  = {addr_q[DATA_WIDTH-1:2], 2'b00};
            mem_wdata = store_wdata;
            mem_wstrb = store_wstrb;
        end
        wb_valid = (state_q == RESP);
        wb_data  = wb_data_q;
        wb_err   = wb_err_q;
    end

endmodule

// File: tb/tb_ysyx_24100012_lsu.sv
module tb_ysyx_24100012_lsu;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_we;
    logic [2:0]  in_funct3;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_data;
    logic        wb_err;

    int vectors;
    int miscompares;

    ysyx_24100012_lsu #(.DATA_WIDTH(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_we         (in_we),
        .in_funct3     (in_funct3),
        .in_addr       (in_addr),
        .in_wdata      (in_wdata),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wstrb     (mem_wstrb),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .wb_valid      (wb_valid),
        .wb_ready      (wb_ready),
        .wb_data       (wb_data),
        .wb_err        (wb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".in_ready"},      {31'd0, in_ready},      32'd1);
        chk({tag, ".mem_req_valid"}, {31'd0, mem_req_valid}, 32'd0);
        chk({tag, ".mem_we"},        {31'd0, mem_we},        32'd0);
        chk({tag, ".mem_addr"},      mem_addr,               32'd0);
        chk({tag, ".mem_wdata"},     mem_wdata,              32'd0);
        chk({tag, ".mem_wstrb"},     {28'd0, mem_wstrb},     32'd0);
        chk({tag, ".wb_valid"},      {31'd0, wb_valid},      32'd0);
        chk({tag, ".wb_data"},       wb_data,                32'd0);
        chk({tag, ".wb_err"},        {31'd0, wb_err},        32'd0);
    endtask

    // Full access on a zero-wait bus: accept (cycle 0), REQ (1), WAIT (2), RESP (3)
    task automatic run_access(input string tag, input logic we, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input logic [31:0] exp_addr,
                              input logic [31:0] exp_wdata, input logic [3:0] exp_strb,
                              input logic [31:0] exp_wb);
        chk({tag, ".in_ready0"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; in_we = we; in_funct3 = f3; in_addr = addr; in_wdata = wdata;
        tick();
        in_valid = 1'b0; in_we = 1'b0; in_funct3 = 3'b000; in_addr = 32'd0; in_wdata = 32'd0;
        chk({tag, ".req_valid"}, {31'd0, mem_req_valid}, 32'd1);
        chk({tag, ".mem_we"},    {31'd0, mem_we},        {31'd0, we});
        chk({tag, ".mem_addr"},  mem_addr,               exp_addr);
        chk({tag, ".mem_wdata"}, mem_wdata,              exp_wdata);
        chk({tag, ".mem_wstrb"}, {28'd0, mem_wstrb},     {28'd0, exp_strb});
        chk({tag, ".in_ready1"}, {31'd0, in_ready},      32'd0);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        chk({tag, ".wait_req"}, {31'd0, mem_req_valid}, 32'd0);
        chk({tag, ".wait_wb"},  {31'd0, wb_valid},      32'd0);
        mem_rvalid = 1'b1; mem_rdata = rdata;
        tick();
        mem_rvalid = 1'b0; mem_rdata = 32'd0;
        chk({tag, ".wb_valid"}, {31'd0, wb_valid}, 32'd1);
        chk({tag, ".wb_data"},  wb_data,           exp_wb);
        chk({tag, ".wb_err"},   {31'd0, wb_err},   32'd0);
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        chk({tag, ".wb_done"},  {31'd0, wb_valid}, 32'd0);
        chk({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b0;
        in_valid = 1'b0; in_we = 1'b0; in_funct3 = 3'b000; in_addr = 32'd0; in_wdata = 32'd0;
        mem_req_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0; wb_ready = 1'b0;

        // Reset state
        tick();
        tick();
        chk_reset_outputs("reset");
        rst = 1'b1;
        tick();

        // Stores
`ifndef YSYX_24100012_LSU_MISALIGN_EN
        run_access("sw", 1'b1, 3'b010, 32'h8000_0006, 32'hDEAD_BEEF, 32'h1234_5678,
                   32'h8000_0004, 32'hDEAD_BEEF, 4'b1111, 32'h0000_0000);
`else
        run_access("sw", 1'b1, 3'b010, 32'h8000_0004, 32'hDEAD_BEEF, 32'h1234_5678,
                   32'h8000_0004, 32'hDEAD_BEEF, 4'b1111, 32'h0000_0000);
`endif
        run_access("sb", 1'b1, 3'b000, 32'h0000_0201, 32'h1234_56A5, 32'h0,
                   32'h0000_0200, 32'hA5A5_A5A5, 4'b0010, 32'h0000_0000);
        run_access("sh", 1'b1, 3'b001, 32'h0000_0202, 32'h0000_BEEF, 32'h0,
                   32'h0000_0200, 32'hBEEF_BEEF, 4'b1100, 32'h0000_0000);

        // Loads
        run_access("lb", 1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80AB_CDEF,
                   32'h0000_0100, 32'h0, 4'b0000, 32'hFFFF_FF80);
        run_access("lbu", 1'b0, 3'b100, 32'h0000_0103, 32'h0, 32'h80AB_CDEF,
                   32'h0000_0100, 32'h0, 4'b0000, 32'h0000_0080);
        run_access("lb_pos", 1'b0, 3'b000, 32'h0000_0101, 32'h0, 32'h0000_7F00,
                   32'h0000_0100, 32'h0, 4'b0000, 32'h0000_007F);
        run_access("lh", 1'b0, 3'b001, 32'h0000_0102, 32'h0, 32'h8001_1234,
                   32'h0000_0100, 32'h0, 4'b0000, 32'hFFFF_8001);
        run_access("lhu", 1'b0, 3'b101, 32'h0000_0102, 32'h0, 32'h8001_1234,
                   32'h0000_0100, 32'h0, 4'b0000, 32'h0000_8001);
        run_access("lw_f3_110", 1'b0, 3'b110, 32'h0000_0300, 32'h0, 32'hCAFE_F00D,
                   32'h0000_0300, 32'h0, 4'b0000, 32'hCAFE_F00D);

        // Misaligned word load
`ifdef YSYX_24100012_LSU_MISALIGN_EN
        in_valid = 1'b1; in_we = 1'b0; in_funct3 = 3'b010; in_addr = 32'h0000_0102;
        tick();
        in_valid = 1'b0; in_addr = 32'd0;
        chk("mis.wb_valid", {31'd0, wb_valid},      32'd1);
        chk("mis.wb_err",   {31'd0, wb_err},        32'd1);
        chk("mis.wb_data",  wb_data,                32'd0);
        chk("mis.req",      {31'd0, mem_req_valid}, 32'd0);
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        chk("mis.req2",     {31'd0, mem_req_valid}, 32'd0);
        chk("mis.in_ready", {31'd0, in_ready},      32'd1);
`else
        run_access("lw_trunc", 1'b0, 3'b010, 32'h0000_0102, 32'h0, 32'h8765_4321,
                   32'h0000_0100, 32'h0, 4'b0000, 32'h8765_4321);
`endif

        // Request stall: bus fields held for 5 cycles, early rvalid ignored, wb stall
        in_valid = 1'b1; in_we = 1'b1; in_funct3 = 3'b010; in_addr = 32'h0000_0400; in_wdata = 32'h1122_3344;
        tick();
        in_valid = 1'b0; in_we = 1'b0; in_funct3 = 3'b000; in_addr = 32'd0; in_wdata = 32'd0;
        for (int i = 0; i < 5; i++) begin
            chk("stall.req_valid", {31'd0, mem_req_valid}, 32'd1);
            chk("stall.mem_addr",  mem_addr,               32'h0000_0400);
            chk("stall.mem_wdata", mem_wdata,              32'h1122_3344);
            chk("stall.mem_wstrb", {28'd0, mem_wstrb},     32'hF);
            chk("stall.in_ready",  {31'd0, in_ready},      32'd0);
            tick();
        end
        mem_req_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        tick();
        mem_req_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
        chk("early_rvalid.wb_valid", {31'd0, wb_valid},      32'd0);
        chk("early_rvalid.req",      {31'd0, mem_req_valid}, 32'd0);
        tick();
        chk("wait_hold.wb_valid", {31'd0, wb_valid}, 32'd0);
        mem_rvalid = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("wbstall.wb_valid", {31'd0, wb_valid}, 32'd1);
            chk("wbstall.wb_data",  wb_data,           32'd0);
            chk("wbstall.in_ready", {31'd0, in_ready}, 32'd0);
            tick();
        end
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        chk("wbstall.done", {31'd0, in_ready}, 32'd1);

        // Reset while in WAIT, then a stale response after release
        in_valid = 1'b1; in_we = 1'b0; in_funct3 = 3'b010; in_addr = 32'h0000_0500;
        tick();
        in_valid = 1'b0; in_addr = 32'd0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        rst = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        tick();
        rst = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        tick();
        mem_rvalid = 1'b0; mem_rdata = 32'd0;
        chk("stale.wb_valid", {31'd0, wb_valid},      32'd0);
        chk("stale.wb_data",  wb_data,                32'd0);
        chk("stale.in_ready", {31'd0, in_ready},      32'd1);
        chk("stale.req",      {31'd0, mem_req_valid}, 32'd0);
        tick();
        chk("stale.wb_valid2", {31'd0, wb_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ysyx_24100012_lsu.md
# ysyx_24100012_lsu

Load/store unit sitting directly downstream of the execute ALU in the NPC core. It takes the ALU result as the effective address plus store data and a width/sign code. It runs one aligned 32-bit memory transaction over a valid/ready bus and returns sign- or zero-extended load data (or a store-completion token) to writeback. It handles one access at a time, with a four-state FSM.

## Interface
- `DATA_WIDTH`, 32: data/address width; only 32 is supported (4 byte lanes).
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `in_valid` input 1: request from execute stage.
- `in_ready` output 1: LSU can accept a request.
- `in_we` input 1: 1 = store, 0 = load.
- `in_funct3` input 3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `in_addr` input 32: effective address (ALU output).
- `in_wdata` input 32: store data (rs2).
- `mem_req_valid` output 1: bus request.
- `mem_req_ready` input 1: bus accepts request.
- `mem_we` output 1: write enable.
- `mem_addr` output 32: `{addr[31:2],2'b00}`.
- `mem_wdata` output 32: lane-replicated store data.
- `mem_wstrb` output 4: byte strobes; 0000 for loads.
- `mem_rvalid` input 1: bus response (loads and stores), one-cycle pulse.
- `mem_rdata` input 32: read word.
- `wb_valid` output 1: result available.
- `wb_ready` input 1: writeback accepts.
- `wb_data` output 32: extended load data; 0 for stores.
- `wb_err` output 1: misaligned access (see Configuration).

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - `in_ready=1`.
  - On `in_valid`, capture we/funct3/addr/wdata and go to REQ.
  - If the misalignment check fires, go straight to RESP with `wb_err=1`.
- REQ:
  - `mem_req_valid=1`; `mem_*` are driven from the captured registers and are stable until the handshake.
  - On `mem_req_ready`, go to WAIT.
- WAIT:
  - On `mem_rvalid`, register the extended `mem_rdata` into `wb_data` and go to RESP.
  - `mem_rvalid` outside WAIT is ignored.
- RESP:
  - `wb_valid=1`; `wb_data`/`wb_err` are held.
  - On `wb_ready`, go to IDLE.
- Store lanes, with `a=addr[1:0]`:
  - SB: wdata `{4{b}}`, strb `0001<<a`.
  - SH: wdata `{2{h}}`, strb `0011<<{a[1],1'b0}`.
  - SW: wdata as-is, strb `1111`.
- Load extract:
  - B/BU: byte at lane `a`.
  - H/HU: halfword at `a[1]`.
  - W: full word.
  - B/H sign-extend; BU/HU zero-extend.
- funct3 011/110/111 decode as W width.
- Reset, including mid-transaction: state IDLE.
  - All outputs 0 except `in_ready`, which is 1 once in IDLE.
  - Any in-flight bus response arriving later is dropped.

## Timing
- Reset values:
  - `in_ready=1`.
  - `mem_req_valid=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`, `mem_wstrb=0`.
  - `wb_valid=0`, `wb_data=0`, `wb_err=0`.
- Handshake at cycle 0 with a zero-wait bus:
  - `mem_req_valid` in cycle 1.
  - `mem_rvalid` earliest in cycle 2.
  - `wb_valid` in cycle 3 (minimum latency 3).
- Misaligned with the check enabled: `wb_valid` in cycle 1, and no bus request is issued.
- Stalls:
  - `mem_req_ready` low: REQ holds indefinitely.
  - `wb_ready` low: RESP holds indefinitely.
- One outstanding access; `in_ready=0` from the cycle after acceptance until the cycle after the `wb` handshake.
- `mem_rvalid` in the same cycle as the REQ handshake is illegal from the bus and is ignored.

## Configuration
- `YSYX_24100012_LSU_MISALIGN_EN` defined:
  - Misaligned cases are H/HU/SH with `a[0]=1` and W/SW with `a!=0`.
  - These complete via IDLE→RESP with `wb_err=1`, `wb_data=0`, and no bus activity.
- Undefined:
  - No check; `wb_err` is tied 0.
  - Low address bits are truncated per the lane rules (H uses `a[1]`, W ignores `a`).

## Test plan
- **SW:** SW addr 0x8000_0006 data 0xDEADBEEF, macro off → `mem_addr` 0x8000_0004, `wstrb` 1111, `wdata` 0xDEADBEEF; `wb_valid` with `wb_data` 0.
- **LB sign extend:** LB addr 0x103, `mem_rdata` 0x80AB_CDEF → `wb_data` 0xFFFF_FF80. Same with LBU → 0x0000_0080.
- **LH/LHU:** LH addr 0x102, `rdata` 0x8001_1234 → 0xFFFF_8001. LHU → 0x0000_8001.
- **SB lane:** SB addr 0x201 data 0x1234_56A5 → `wdata` 0xA5A5_A5A5, `wstrb` 0010.
- **Misaligned, macro on:** LW addr 0x102 → `wb_valid` cycle 1, `wb_err=1`, `mem_req_valid` never asserted.
- **Stall and reset:**
  - Hold `mem_req_ready=0` for 5 cycles: `mem_*` stable, `in_ready=0`.
  - Assert `rst` low while in WAIT, then pulse `mem_rvalid` after release: all outputs at reset values, no `wb_valid`.
